// File: rtl/fastram_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module   : fastram_bridge_if
//  Brief    : Level req / pulse ack bus between the fast-RAM bridge and the
//             SDRAM controller.
//  Revision : 1.0  initial release
// ============================================================================
interface fastram_bridge_if #(
    parameter int ADDR_W = 23
);
    logic              sdram_req;
    logic              sdram_we;
    logic [ADDR_W-1:0] sdram_addr;
    logic [7:0]        sdram_wdata;
    logic              sdram_ack;
    logic [7:0]        sdram_rdata;

    modport master (
        output sdram_req,
        output sdram_we,
        output sdram_addr,
        output sdram_wdata,
        input  sdram_ack,
        input  sdram_rdata
    );

    modport slave (
        input  sdram_req,
        input  sdram_we,
        input  sdram_addr,
        input  sdram_wdata,
        output sdram_ack,
        output sdram_rdata
    );
endinterface
`default_nettype wire

// File: rtl/fastram_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : fastram_bridge
//  Brief    : Turns the CPU fast-RAM strobe into a registered SDRAM req/ack
//             transaction with CPU stall, read-data return and timeout abort.
//             Define FASTRAM_RDCACHE_EN for a one-entry read cache.
//  Revision : 1.0  initial release
// ============================================================================
module fastram_bridge #(
    parameter int ADDR_W      = 23,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              fast_clk,
    input  logic              cpu_ce,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              cpu_wait,
    output logic              timeout_err,
    fastram_bridge_if.master  sdram
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0] c_term_cnt = 8'(TIMEOUT_CYC - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_start;
    logic              w_ack_done;
    logic              w_abort;
    logic              w_hit;
    logic [7:0]        w_hit_data;
    logic [7:0]        r_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_wdata;
    logic [7:0]        r_dout;
    logic              r_tmo;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Ack is checked before the terminal count so a coincident ack wins.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_ack_done  = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (fast_clk && cpu_ce && !w_hit) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (sdram.sdram_ack) begin
                    w_ack_done  = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (r_cnt == c_term_cnt) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= 8'd0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 8'd0;
            r_dout  <= 8'd0;
            r_tmo   <= 1'b0;
        end else begin
            r_tmo <= w_abort;

            if (w_start) begin
                r_addr  <= cpu_addr;
                r_we    <= cpu_we;
                r_wdata <= cpu_din;
                r_cnt   <= 8'd0;
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt + 8'd1;
            end

            if (w_ack_done && !r_we) begin
                r_dout <= sdram.sdram_rdata;
            end else if (w_abort && !r_we) begin
                r_dout <= 8'hFF;
            end else if (w_hit) begin
                r_dout <= w_hit_data;
            end
        end
    end

`ifdef FASTRAM_RDCACHE_EN
    logic              r_cache_vld;
    logic [ADDR_W-1:0] r_cache_tag;
    logic [7:0]        r_cache_data;

    assign w_hit = (r_state == S_IDLE) && fast_clk && cpu_ce && !cpu_we
                && r_cache_vld && (r_cache_tag == cpu_addr);
    assign w_hit_data = r_cache_data;

    // Aborted accesses drop the entry since the SDRAM state is uncertain.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_cache_vld  <= 1'b0;
            r_cache_tag  <= '0;
            r_cache_data <= 8'd0;
        end else if (w_ack_done && !r_we) begin
            r_cache_vld  <= 1'b1;
            r_cache_tag  <= r_addr;
            r_cache_data <= sdram.sdram_rdata;
        end else if (w_abort) begin
            r_cache_vld <= 1'b0;
        end else if (w_start && cpu_we && (cpu_addr == r_cache_tag)) begin
            r_cache_vld <= 1'b0;
        end
    end
`else
    assign w_hit      = 1'b0;
    assign w_hit_data = 8'h00;
`endif

    assign sdram.sdram_req   = (r_state == S_BUSY);
    assign sdram.sdram_we    = r_we;
    assign sdram.sdram_addr  = r_addr;
    assign sdram.sdram_wdata = r_wdata;
    assign cpu_wait          = (r_state == S_BUSY);
    assign cpu_dout          = r_dout;
    assign timeout_err       = r_tmo;

endmodule
`default_nettype wire

// File: tb/tb_fastram_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fastram_bridge
//  Brief    : Randomised self-checking bench for fastram_bridge against a
//             transaction-level model (latency, data return, timeout, cache).
//  Revision : 1.0  initial release
// ============================================================================
module tb_fastram_bridge;

    localparam int ADDR_W      = 23;
    localparam int TIMEOUT_CYC = 255;
`ifdef FASTRAM_RDCACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic              clk_sys = 1'b0;
    logic              reset_n;
    logic              fast_clk;
    logic              cpu_ce;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_din;
    logic [7:0]        cpu_dout;
    logic              cpu_wait;
    logic              timeout_err;

    fastram_bridge_if #(.ADDR_W(ADDR_W)) sd_if ();

    fastram_bridge #(
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .fast_clk    (fast_clk),
        .cpu_ce      (cpu_ce),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_din     (cpu_din),
        .cpu_dout    (cpu_dout),
        .cpu_wait    (cpu_wait),
        .timeout_err (timeout_err),
        .sdram       (sd_if.master)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: what the CPU should see and what the cache holds
    logic [7:0]        m_dout;
    bit                m_valid;
    logic [ADDR_W-1:0] m_tag;
    logic [7:0]        m_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // One CPU access. n_ack>0: ack is presented n_ack cycles after req rises;
    // n_ack==0: ack withheld so the access must time out.
    task automatic run_access(input bit we, input logic [ADDR_W-1:0] addr,
                              input logic [7:0] din, input int n_ack,
                              input logic [7:0] rd);
        bit hit;
        bit timed_out;
        bit stable;
        bit req_eq_wait;
        int cycles;
        int exp_cycles;

        hit = CACHE_EN && !we && m_valid && (m_tag == addr);

        fast_clk = 1'b1; cpu_ce = 1'b1; cpu_we = we; cpu_addr = addr; cpu_din = din;
        tick();
        fast_clk = 1'b0;
        cpu_ce   = 1'($urandom);
        cpu_we   = 1'($urandom);
        cpu_addr = ADDR_W'($urandom);
        cpu_din  = 8'($urandom);

        if (hit) begin
            m_dout = m_data;
            check("hit_req",  32'(sd_if.sdram_req), 32'd0);
            check("hit_wait", 32'(cpu_wait),        32'd0);
            check("hit_dout", 32'(cpu_dout),        32'(m_dout));
            return;
        end

        if (we && (m_tag == addr)) m_valid = 1'b0;

        cycles      = 0;
        stable      = 1'b1;
        req_eq_wait = 1'b1;
        while (sd_if.sdram_req === 1'b1 && cycles < TIMEOUT_CYC + 8) begin
            cycles++;
            if (sd_if.sdram_addr !== addr || sd_if.sdram_we !== we || sd_if.sdram_wdata !== din)
                stable = 1'b0;
            if (cpu_wait !== sd_if.sdram_req) req_eq_wait = 1'b0;
            if (n_ack > 0 && cycles == n_ack + 1) begin
                sd_if.sdram_ack   = 1'b1;
                sd_if.sdram_rdata = rd;
            end else begin
                sd_if.sdram_rdata = 8'($urandom);
            end
            fast_clk = ($urandom_range(0, 3) == 0);
            cpu_ce   = 1'($urandom);
            tick();
            sd_if.sdram_ack   = 1'b0;
            sd_if.sdram_rdata = 8'($urandom);
            fast_clk          = 1'b0;
        end

        timed_out  = !(n_ack > 0 && n_ack < TIMEOUT_CYC);
        exp_cycles = timed_out ? TIMEOUT_CYC : n_ack + 1;
        if (!we) begin
            if (timed_out) begin
                m_dout = 8'hFF;
            end else begin
                m_dout  = rd;
                m_valid = 1'b1;
                m_tag   = addr;
                m_data  = rd;
            end
        end
        if (timed_out) m_valid = 1'b0;

        check("wait_cycles",  32'(cycles),      32'(exp_cycles));
        check("bus_stable",   32'(stable),      32'd1);
        check("req_eq_wait",  32'(req_eq_wait), 32'd1);
        check("wait_release", 32'(cpu_wait),    32'd0);
        check("timeout_err",  32'(timeout_err), 32'(timed_out));
        check("dout",         32'(cpu_dout),    32'(m_dout));

        // A strobe during the one-cycle gap after completion must be ignored.
        if ($urandom_range(0, 1) == 1) begin
            fast_clk = 1'b1; cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = addr;
        end
        tick();
        fast_clk = 1'b0;
        check("gap_req",   32'(sd_if.sdram_req), 32'd0);
        check("err_pulse", 32'(timeout_err),     32'd0);
        check("dout_hold", 32'(cpu_dout),        32'(m_dout));
    endtask

    task automatic spurious_ack();
        sd_if.sdram_ack   = 1'b1;
        sd_if.sdram_rdata = 8'($urandom);
        tick();
        sd_if.sdram_ack = 1'b0;
        check("spur_dout", 32'(cpu_dout),        32'(m_dout));
        check("spur_req",  32'(sd_if.sdram_req), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; fast_clk = 1'b0; cpu_ce = 1'b0; cpu_we = 1'b0;
        cpu_addr = '0; cpu_din = 8'd0;
        sd_if.sdram_ack = 1'b0; sd_if.sdram_rdata = 8'd0;
        m_dout = 8'h00; m_valid = 1'b0; m_tag = '0; m_data = 8'h00;

        repeat (3) tick();
        check("rst_dout",  32'(cpu_dout),          32'd0);
        check("rst_wait",  32'(cpu_wait),          32'd0);
        check("rst_req",   32'(sd_if.sdram_req),   32'd0);
        check("rst_we",    32'(sd_if.sdram_we),    32'd0);
        check("rst_addr",  32'(sd_if.sdram_addr),  32'd0);
        check("rst_wdata", 32'(sd_if.sdram_wdata), 32'd0);
        check("rst_err",   32'(timeout_err),       32'd0);
        reset_n = 1'b1;
        tick();

        run_access(1'b0, 23'h012345, 8'h00, 3,   8'hA5);
        run_access(1'b1, 23'h000400, 8'h3C, 1,   8'h00);
        run_access(1'b0, 23'h000777, 8'h00, 0,   8'h00);
        run_access(1'b0, 23'h000778, 8'h00, 254, 8'hC3);
        spurious_ack();
        run_access(1'b1, 23'h000779, 8'h5A, 0,   8'h00);

        run_access(1'b0, 23'h7F0010, 8'h00, 2, 8'h11);
        run_access(1'b0, 23'h7F0010, 8'h00, 2, 8'h22);
        run_access(1'b1, 23'h7F0010, 8'h99, 1, 8'h00);
        run_access(1'b0, 23'h7F0010, 8'h00, 2, 8'h33);

        // Reset asserted while the access is outstanding
        fast_clk = 1'b1; cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = 23'h001234;
        tick();
        fast_clk = 1'b0;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check("arst_req",  32'(sd_if.sdram_req), 32'd0);
        check("arst_wait", 32'(cpu_wait),        32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        m_dout = 8'h00; m_valid = 1'b0;
        sd_if.sdram_ack = 1'b1; sd_if.sdram_rdata = 8'h5A;
        tick();
        sd_if.sdram_ack = 1'b0;
        check("late_ack_req",  32'(sd_if.sdram_req), 32'd0);
        check("late_ack_wait", 32'(cpu_wait),        32'd0);
        check("late_ack_dout", 32'(cpu_dout),        32'd0);
        check("late_ack_err",  32'(timeout_err),     32'd0);
        tick();
        check("post_rst_idle", 32'(sd_if.sdram_req), 32'd0);

        for (int i = 0; i < 60; i++) begin
            logic [ADDR_W-1:0] a;
            case ($urandom_range(0, 3))
                0:       a = 23'h7F0010;
                1:       a = 23'h000400;
                2:       a = 23'h012345;
                default: a = ADDR_W'($urandom);
            endcase
            run_access(1'($urandom), a, 8'($urandom), $urandom_range(1, 10), 8'($urandom));
            if ($urandom_range(0, 4) == 0) spurious_ack();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
